// File: rtl/aes_inv_round_ctrl_if.sv
// Ciphertext/plaintext handshakes, key-store lookup and inverse-round datapath
// control for the AES-128 inverse round controller.
interface aes_inv_round_ctrl_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic [3:0]   rk_idx;
    logic [127:0] rk_data;
    logic         dp_start;
    logic [127:0] dp_in;
    logic [3:0]   dp_key_idx;
    logic         dp_last;
    logic [127:0] dp_out;

    modport master (
        input  in_valid, in_data, out_ready, rk_data, dp_out,
        output in_ready, out_valid, out_data, rk_idx, dp_start, dp_in, dp_key_idx, dp_last
    );

    modport slave (
        output in_valid, in_data, out_ready, rk_data, dp_out,
        input  in_ready, out_valid, out_data, rk_idx, dp_start, dp_in, dp_key_idx, dp_last
    );
endinterface

// File: rtl/aes_inv_round_ctrl.sv
// Sequences one AES-128 block through the inverse cipher: AddRoundKey(NR), then
// rounds NR-1..0 issued to a shared inverse-round datapath of fixed latency.
module aes_inv_round_ctrl #(
    parameter int unsigned DP_LATENCY = 1,
    parameter int unsigned NR         = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    aes_inv_round_ctrl_if.master bus,
    output logic                 busy
);
    localparam int unsigned DW = 128;
    localparam int unsigned IW = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        INIT  = 3'd1,
        ISSUE = 3'd2,
        WAIT  = 3'd3,
        DONE  = 3'd4
    } fsm_t;

    fsm_t          fsm_q, fsm_d;
    logic [DW-1:0] state_q, state_d;
    logic [IW-1:0] round_q, round_d;
    logic [IW-1:0] cnt_q, cnt_d;
    logic [IW-1:0] rk_idx_q, rk_idx_d;
    logic [IW-1:0] key_idx_q, key_idx_d;
    logic          in_ready_q, in_ready_d;
    logic          out_valid_q, out_valid_d;
    logic          dp_start_q, dp_start_d;
    logic          dp_last_q, dp_last_d;
    logic          busy_q, busy_d;
    logic          in_round;

    // Next state plus registered outputs decoded from the state being entered
    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        round_d = round_q;
        cnt_d   = cnt_q;

        case (fsm_q)
            IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    state_d = bus.in_data;
                    round_d = IW'(NR - 1);
                    fsm_d   = INIT;
                end
            end
            INIT: begin
                state_d = state_q ^ bus.rk_data;
                fsm_d   = ISSUE;
            end
            ISSUE: begin
                cnt_d = IW'(DP_LATENCY - 1);
                fsm_d = WAIT;
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = bus.dp_out;
                    if (round_q == '0) begin
                        fsm_d = DONE;
                    end else begin
                        round_d = round_q - IW'(1);
                        fsm_d   = ISSUE;
                    end
                end else begin
                    cnt_d = cnt_q - IW'(1);
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    fsm_d = IDLE;
                end
            end
            default: fsm_d = IDLE;
        endcase

        in_round    = (fsm_d == ISSUE) || (fsm_d == WAIT);
        in_ready_d  = (fsm_d == IDLE);
        out_valid_d = (fsm_d == DONE);
        busy_d      = (fsm_d != IDLE);
        dp_start_d  = (fsm_d == ISSUE);
        dp_last_d   = in_round && (round_d == '0);
        key_idx_d   = in_round ? round_d : '0;
        rk_idx_d    = (fsm_d == INIT) ? IW'(NR) : key_idx_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q       <= IDLE;
            state_q     <= '0;
            round_q     <= '0;
            cnt_q       <= '0;
            rk_idx_q    <= '0;
            key_idx_q   <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            dp_start_q  <= 1'b0;
            dp_last_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            state_q     <= state_d;
            round_q     <= round_d;
            cnt_q       <= cnt_d;
            rk_idx_q    <= rk_idx_d;
            key_idx_q   <= key_idx_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            dp_start_q  <= dp_start_d;
            dp_last_q   <= dp_last_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_data   = state_q;
    assign bus.dp_in      = state_q;
    assign bus.rk_idx     = rk_idx_q;
    assign bus.dp_key_idx = key_idx_q;
    assign bus.dp_start   = dp_start_q;
    assign bus.dp_last    = dp_last_q;
    assign busy           = busy_q;
endmodule

// File: tb/tb_aes_inv_round_ctrl.sv
// Bench for aes_inv_round_ctrl: two instances (datapath latency 1 and 3) driven
// against an AES-128 key store, datapath model and whole-block decrypt reference.
module tb_aes_inv_round_ctrl;
    localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst        [2];
    logic         in_valid   [2];
    logic [127:0] in_data    [2];
    logic         out_ready  [2];
    logic         in_ready   [2];
    logic         out_valid  [2];
    logic         busy       [2];
    logic         dp_start   [2];
    logic         dp_last    [2];
    logic [127:0] out_data   [2];
    logic [127:0] dp_in      [2];
    logic [3:0]   rk_idx     [2];
    logic [3:0]   dp_key_idx [2];

    logic [7:0]   sbox   [256];
    logic [7:0]   isbox  [256];
    logic [127:0] rk_tab [16];

    int n_tests = 0;
    int n_fail  = 0;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s, input bit inv);
        logic [127:0] r;
        for (int i = 0; i < 16; i++)
            r[127-8*i -: 8] = inv ? isbox[s[127-8*i -: 8]] : sbox[s[127-8*i -: 8]];
        return r;
    endfunction

    function automatic logic [127:0] shift_rows(input logic [127:0] s, input bit inv);
        logic [127:0] r;
        int src;
        for (int c = 0; c < 4; c++) begin
            for (int rr = 0; rr < 4; rr++) begin
                src = inv ? (c - rr + 4) % 4 : (c + rr) % 4;
                r[127-8*(4*c+rr) -: 8] = s[127-8*(4*src+rr) -: 8];
            end
        end
        return r;
    endfunction

    function automatic logic [127:0] mix_cols(input logic [127:0] s, input bit inv);
        logic [7:0]   coef [4];
        logic [127:0] r;
        logic [7:0]   acc;
        if (inv) begin
            coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
        end else begin
            coef[0] = 8'h02; coef[1] = 8'h03; coef[2] = 8'h01; coef[3] = 8'h01;
        end
        for (int c = 0; c < 4; c++) begin
            for (int rr = 0; rr < 4; rr++) begin
                acc = 8'h00;
                for (int k = 0; k < 4; k++)
                    acc = acc ^ gmul(s[127-8*(4*c+k) -: 8], coef[(k - rr + 4) % 4]);
                r[127-8*(4*c+rr) -: 8] = acc;
            end
        end
        return r;
    endfunction

    // One inverse round as the shared datapath would compute it
    function automatic logic [127:0] inv_round(input logic [127:0] s, input logic [127:0] k,
                                               input logic last);
        logic [127:0] t;
        t = sub_bytes(shift_rows(s, 1'b1), 1'b1) ^ k;
        return last ? t : mix_cols(t, 1'b1);
    endfunction

    function automatic logic [127:0] aes_dec(input logic [127:0] ct);
        logic [127:0] s;
        s = ct ^ rk_tab[10];
        for (int r = 9; r >= 0; r--) s = inv_round(s, rk_tab[r], r == 0);
        return s;
    endfunction

    task automatic build_tables();
        logic [7:0]  inv;
        logic [7:0]  s;
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rcon;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                ^ {inv[3:0], inv[7:4]} ^ 8'h63;
            sbox[x]  = s;
            isbox[s] = 8'(x);
        end
        for (int i = 0; i < 4; i++) w[i] = KEY[127-32*i -: 32];
        rcon = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rcon, 24'h0};
                rcon = gmul(rcon, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 16; r++)
            rk_tab[r] = (r <= 10) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : '0;
    endtask

    for (genvar g = 0; g < 2; g++) begin : lane
        localparam int unsigned LAT = (g == 0) ? 1 : 3;
        aes_inv_round_ctrl_if bus ();
        logic [127:0] pipe [LAT];

        assign bus.in_valid  = in_valid[g];
        assign bus.in_data   = in_data[g];
        assign bus.out_ready = out_ready[g];
        assign bus.rk_data   = rk_tab[bus.rk_idx];
        assign bus.dp_out    = pipe[LAT-1];
        assign in_ready[g]   = bus.in_ready;
        assign out_valid[g]  = bus.out_valid;
        assign out_data[g]   = bus.out_data;
        assign dp_start[g]   = bus.dp_start;
        assign dp_last[g]    = bus.dp_last;
        assign dp_in[g]      = bus.dp_in;
        assign rk_idx[g]     = bus.rk_idx;
        assign dp_key_idx[g] = bus.dp_key_idx;

        aes_inv_round_ctrl #(.DP_LATENCY(LAT), .NR(10)) u_dut (
            .clk  (clk),
            .rst  (rst[g]),
            .bus  (bus),
            .busy (busy[g])
        );

        // Datapath model: result valid exactly LAT cycles after dp_start, junk otherwise
        always @(posedge clk) begin
            pipe[0] <= bus.dp_start ? inv_round(bus.dp_in, rk_tab[bus.dp_key_idx], bus.dp_last)
                                    : {$urandom, $urandom, $urandom, $urandom};
            for (int k = 1; k < int'(LAT); k++) pipe[k] <= pipe[k-1];
        end
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Push one block, trace the round sequence, apply backpressure, complete the handshake
    task automatic run_block(input int ln, input logic [127:0] ct, input int hold,
                             input logic nxt_valid, input logic [127:0] nxt_data,
                             input logic [127:0] exp);
        int lat;
        int cyc;
        int starts;
        int guard;
        lat   = (ln == 0) ? 1 : 3;
        guard = 0;
        while (!in_ready[ln] && guard < 50) begin
            step();
            guard++;
        end
        check("idle_in_ready", 128'(in_ready[ln]), 128'(1));
        in_valid[ln] = 1'b1;
        in_data[ln]  = ct;
        step();
        in_valid[ln] = nxt_valid;
        in_data[ln]  = nxt_data;
        check("init_rk_idx", 128'(rk_idx[ln]), 128'(10));
        cyc    = 1;
        starts = 0;
        while (!out_valid[ln] && cyc < 200) begin
            check("run_in_ready", 128'(in_ready[ln]), 128'(0));
            check("run_busy", 128'(busy[ln]), 128'(1));
            if (dp_start[ln]) begin
                check("issue_key_idx", 128'(dp_key_idx[ln]), 128'(9 - starts));
                check("issue_rk_idx", 128'(rk_idx[ln]), 128'(9 - starts));
                check("issue_last", 128'(dp_last[ln]), 128'(starts == 9));
                check("issue_cycle", 128'(cyc), 128'(2 + starts * (lat + 1)));
                starts++;
            end else begin
                check("hold_last", 128'(dp_last[ln]), 128'(starts == 10));
                if (starts > 0)
                    check("hold_key_idx", 128'(dp_key_idx[ln]), 128'(10 - starts));
            end
            step();
            cyc++;
        end
        check("out_latency", 128'(cyc), 128'(2 + 10 * (lat + 1)));
        check("start_count", 128'(starts), 128'(10));
        check("out_data", out_data[ln], exp);
        for (int i = 0; i < hold; i++) begin
            check("bp_valid", 128'(out_valid[ln]), 128'(1));
            check("bp_data", out_data[ln], exp);
            check("bp_in_ready", 128'(in_ready[ln]), 128'(0));
            step();
        end
        out_ready[ln] = 1'b1;
        step();
        out_ready[ln] = 1'b0;
        check("post_valid", 128'(out_valid[ln]), 128'(0));
        check("post_in_ready", 128'(in_ready[ln]), 128'(1));
        check("post_busy", 128'(busy[ln]), 128'(0));
    endtask

    task automatic check_reset_state(input int ln, input string tag);
        check({tag, "_busy"}, 128'(busy[ln]), 128'(0));
        check({tag, "_in_ready"}, 128'(in_ready[ln]), 128'(1));
        check({tag, "_out_valid"}, 128'(out_valid[ln]), 128'(0));
        check({tag, "_dp_start"}, 128'(dp_start[ln]), 128'(0));
        check({tag, "_dp_last"}, 128'(dp_last[ln]), 128'(0));
        check({tag, "_rk_idx"}, 128'(rk_idx[ln]), 128'(0));
        check({tag, "_key_idx"}, 128'(dp_key_idx[ln]), 128'(0));
        check({tag, "_state"}, dp_in[ln], 128'(0));
    endtask

    logic [127:0] ct;
    int           ln;

    initial begin
        build_tables();
        for (int i = 0; i < 2; i++) begin
            rst[i]       = 1'b1;
            in_valid[i]  = 1'b0;
            in_data[i]   = '0;
            out_ready[i] = 1'b0;
        end
        repeat (3) step();
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        check_reset_state(0, "rst0");
        check_reset_state(1, "rst1");

        // FIPS-197 C.1 with 5 cycles of backpressure
        run_block(0, CT, 5, 1'b0, '0, PT);

        // Back-to-back with in_valid held: C.1 then all-zero ciphertext
        run_block(0, CT, 0, 1'b1, '0, PT);
        run_block(0, '0, 2, 1'b0, '0, aes_dec('0));

        // Reset during the 4th WAIT (cycle 9 at latency 1)
        in_valid[0] = 1'b1;
        in_data[0]  = CT;
        step();
        in_valid[0] = 1'b0;
        repeat (8) step();
        check("wait4_key_idx", 128'(dp_key_idx[0]), 128'(6));
        check("wait4_no_start", 128'(dp_start[0]), 128'(0));
        rst[0] = 1'b1;
        step();
        rst[0] = 1'b0;
        check_reset_state(0, "midrst");
        run_block(0, CT, 0, 1'b0, '0, PT);

        // Reset wins over a simultaneous in_valid
        in_valid[0] = 1'b1;
        in_data[0]  = CT;
        rst[0]      = 1'b1;
        step();
        rst[0]      = 1'b0;
        in_valid[0] = 1'b0;
        check_reset_state(0, "rstvld");
        step();
        check("rstvld_not_taken", 128'(busy[0]), 128'(0));

        // Datapath latency 3
        run_block(1, CT, 1, 1'b0, '0, PT);

        // Random ciphertexts on both latencies
        for (int i = 0; i < 6; i++) begin
            ln = i % 2;
            ct = {$urandom, $urandom, $urandom, $urandom};
            run_block(ln, ct, int'($urandom_range(0, 3)), 1'b0, '0, aes_dec(ct));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
